// File: rtl/sigma_delta_dac.sv
// Second-order 1-bit sigma-delta DAC with soft mute/unmute gain ramp.
// Define SIGMA_DELTA_DITHER_EN to add 2-bit LFSR dither ahead of the first integrator.
module sigma_delta_dac #(
  parameter int unsigned MOD_DIV   = 4,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               enable,
  output logic               pdm_out,
  output logic               muted,
  output logic               overload
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned G_W    = 9;
  localparam int unsigned X_W    = 16;
  localparam int unsigned P_W    = 26;
  localparam int unsigned I1_W   = 20;
  localparam int unsigned I2_W   = 24;
  localparam int unsigned S1_W   = 22;
  localparam int unsigned S2_W   = 26;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MOD_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP - 1);
  localparam logic [G_W-1:0]    G_MAX     = G_W'(256);

  localparam logic signed [S1_W-1:0] FB_POS = S1_W'(32767);
  localparam logic signed [S1_W-1:0] FB_NEG = S1_W'(-32768);
  localparam logic signed [S1_W-1:0] I1_MAX = S1_W'(262144);
  localparam logic signed [S1_W-1:0] I1_MIN = S1_W'(-262144);
  localparam logic signed [S2_W-1:0] I2_MAX = S2_W'(4194304);
  localparam logic signed [S2_W-1:0] I2_MIN = S2_W'(-4194304);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                   r_state;
  logic [DIV_W-1:0]         r_div;
  logic [STEP_W-1:0]        r_step;
  logic [G_W-1:0]           r_g;
  logic signed [X_W-1:0]    r_sample;
  logic signed [I1_W-1:0]   r_int1;
  logic signed [I2_W-1:0]   r_int2;

  logic                     w_tick;
  logic signed [P_W-1:0]    w_prod;
  logic signed [X_W-1:0]    w_x;
  logic signed [S1_W-1:0]   w_xd;
  logic signed [S1_W-1:0]   w_fb;
  logic signed [S1_W-1:0]   w_sum1;
  logic signed [S1_W-1:0]   w_int1_c;
  logic signed [S2_W-1:0]   w_sum2;
  logic signed [S2_W-1:0]   w_int2_c;
  logic                     w_clamp1;
  logic                     w_clamp2;
  logic                     w_pdm_next;

`ifdef SIGMA_DELTA_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
`endif

  assign w_tick = (r_div == DIV_LAST);

  // Gain scaling and the two clamped integrators for the current tick.
  always_comb begin
    w_prod = r_sample * $signed({1'b0, r_g});
    w_x    = X_W'(w_prod >>> 8);
`ifdef SIGMA_DELTA_DITHER_EN
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    w_xd        = S1_W'(w_x) + S1_W'($signed(r_lfsr[1:0]));
`else
    w_xd        = S1_W'(w_x);
`endif
    w_fb   = pdm_out ? FB_POS : FB_NEG;

    w_sum1   = S1_W'(r_int1) + w_xd - w_fb;
    w_int1_c = w_sum1;
    w_clamp1 = 1'b0;
    if (w_sum1 > I1_MAX) begin
      w_int1_c = I1_MAX;
      w_clamp1 = 1'b1;
    end else if (w_sum1 < I1_MIN) begin
      w_int1_c = I1_MIN;
      w_clamp1 = 1'b1;
    end

    w_sum2   = S2_W'(r_int2) + S2_W'(w_int1_c) - S2_W'(w_fb);
    w_int2_c = w_sum2;
    w_clamp2 = 1'b0;
    if (w_sum2 > I2_MAX) begin
      w_int2_c = I2_MAX;
      w_clamp2 = 1'b1;
    end else if (w_sum2 < I2_MIN) begin
      w_int2_c = I2_MIN;
      w_clamp2 = 1'b1;
    end

    w_pdm_next = ~w_int2_c[S2_W-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= MUTED;
      r_div    <= '0;
      r_step   <= '0;
      r_g      <= '0;
      r_sample <= '0;
      r_int1   <= '0;
      r_int2   <= '0;
      pdm_out  <= 1'b0;
      muted    <= 1'b1;
      overload <= 1'b0;
`ifdef SIGMA_DELTA_DITHER_EN
      r_lfsr   <= LFSR_SEED;
`endif
    end else begin
      overload <= 1'b0;
      r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        r_sample <= sample_in;
        if (r_state == MUTED) begin
          // Idle: zero-mean alternating pattern with cleared integrators.
          r_g     <= '0;
          r_int1  <= '0;
          r_int2  <= '0;
          pdm_out <= ~pdm_out;
`ifdef SIGMA_DELTA_DITHER_EN
          r_lfsr  <= LFSR_SEED;
`endif
          if (enable) begin
            r_state <= RAMP_UP;
            r_step  <= '0;
            muted   <= 1'b0;
          end
        end else begin
          r_int1   <= I1_W'(w_int1_c);
          r_int2   <= I2_W'(w_int2_c);
          pdm_out  <= w_pdm_next;
          overload <= w_clamp1 | w_clamp2;
`ifdef SIGMA_DELTA_DITHER_EN
          r_lfsr   <= w_lfsr_next;
`endif
          case (r_state)
            RAMP_UP: begin
              if (!enable) begin
                r_state <= RAMP_DOWN;
                r_step  <= '0;
              end else if (r_step == STEP_LAST) begin
                r_step <= '0;
                r_g    <= r_g + G_W'(1);
                if (r_g == G_W'(255)) r_state <= RUN;
              end else begin
                r_step <= r_step + STEP_W'(1);
              end
            end
            RUN: begin
              r_g <= G_MAX;
              if (!enable) begin
                r_state <= RAMP_DOWN;
                r_step  <= '0;
              end
            end
            RAMP_DOWN: begin
              if (enable) begin
                r_state <= RAMP_UP;
                r_step  <= '0;
              end else if (r_step == STEP_LAST) begin
                r_step <= '0;
                r_g    <= r_g - G_W'(1);
                // Last gain step lands in MUTED with the loop state dropped.
                if (r_g == G_W'(1)) begin
                  r_state <= MUTED;
                  muted   <= 1'b1;
                  r_int1  <= '0;
                  r_int2  <= '0;
                end
              end else begin
                r_step <= r_step + STEP_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac: reset, idle toggling, ramps, densities, overload, mid-run reset.
module tb_sigma_delta_dac;

  localparam int unsigned MOD_DIV   = 4;
  localparam int unsigned RAMP_STEP = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] sample_in;
  logic               pdm_out;
  logic               muted;
  logic               overload;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sigma_delta_dac #(.MOD_DIV(MOD_DIV), .RAMP_STEP(RAMP_STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .enable    (enable),
    .pdm_out   (pdm_out),
    .muted     (muted),
    .overload  (overload)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n modulator ticks, landing just after a tick edge.
  task automatic ticks(input int n);
    repeat (n * MOD_DIV) @(posedge clk);
    #1;
  endtask

  initial begin
    int ones;
    int ovl;
    int dbl;
    int oob;
    int bad_mono;
    int prev_g;
    logic prev_ovl;

    rst = 1'b0; enable = 1'b0; sample_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_muted", 32'(muted), 1);
    check("rst_pdm", 32'(pdm_out), 0);
    check("rst_ovl", 32'(overload), 0);
    check("rst_g", 32'(dut.r_g), 0);

    // Idle pattern: first tick MOD_DIV clocks after release, then toggle per tick.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_first_tick_pdm", 32'(pdm_out), 0);
    @(posedge clk);
    #1;
    check("first_tick_pdm", 32'(pdm_out), 1);
    check("idle_muted", 32'(muted), 1);
    ticks(1);
    check("idle_toggle0", 32'(pdm_out), 0);
    ticks(1);
    check("idle_toggle1", 32'(pdm_out), 1);
    check("idle_int1", 32'(dut.r_int1), 0);
    check("idle_int2", 32'(dut.r_int2), 0);

    // Enable glitch between ticks is ignored.
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_muted", 32'(muted), 1);
    check("glitch_pdm", 32'(pdm_out), 0);

    // Unmute with silence: 512 ticks of ramp to unity gain.
    enable = 1'b1;
    ticks(1);
    check("unmute_muted", 32'(muted), 0);
    check("unmute_g0", 32'(dut.r_g), 0);
    ticks(511);
    check("ramp_g255", 32'(dut.r_g), 255);
    ticks(1);
    check("run_g256", 32'(dut.r_g), 256);
    ones = 0;
    for (int t = 0; t < 4096; t++) begin
      ticks(1);
      ones += int'(pdm_out);
    end
    check("density_50", 32'(ones >= 2008 && ones <= 2088), 1);

    // Half-scale positive input: 75% ones, no clamping.
    sample_in = 16'sh4000;
    ticks(16);
    ones = 0; ovl = 0;
    for (int t = 0; t < 8192; t++) begin
      ticks(1);
      ones += int'(pdm_out);
      ovl  += int'(overload);
    end
    check("density_75", 32'(ones >= 6103 && ones <= 6185), 1);
    check("no_overload_75", 32'(ovl), 0);

    // Full-scale input: saturating but bounded, single-cycle overload pulses.
    sample_in = 16'sh7FFF;
    ticks(8);
    ones = 0; dbl = 0; oob = 0; prev_ovl = 1'b0;
    for (int t = 0; t < 2048; t++) begin
      for (int c = 0; c < int'(MOD_DIV); c++) begin
        @(posedge clk);
        #1;
        if (overload && prev_ovl) dbl++;
        prev_ovl = overload;
      end
      ones += int'(pdm_out);
      if (dut.r_int1 > 20'sd262144 || dut.r_int1 < -20'sd262144) oob++;
      if (dut.r_int2 > 24'sd4194304 || dut.r_int2 < -24'sd4194304) oob++;
    end
    check("density_full", 32'(ones >= 2028), 1);
    check("ovl_single_cycle", 32'(dbl), 0);
    check("int_in_range", 32'(oob), 0);

    // Reset in RUN drops everything on the next edge.
    sample_in = 16'sh4000;
    ticks(8);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_muted", 32'(muted), 1);
    check("midrst_pdm", 32'(pdm_out), 0);
    check("midrst_ovl", 32'(overload), 0);
    check("midrst_g", 32'(dut.r_g), 0);
    check("midrst_int1", 32'(dut.r_int1), 0);
    check("midrst_int2", 32'(dut.r_int2), 0);
    enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (MOD_DIV) @(posedge clk);
    #1;
    check("restart_muted", 32'(muted), 1);
    check("restart_pdm", 32'(pdm_out), 1);

    // Abort an unmute at g=100 and ramp back down to MUTED.
    enable = 1'b1;
    ticks(1);
    check("reup_muted", 32'(muted), 0);
    ticks(200);
    check("ramp_g100", 32'(dut.r_g), 100);
    enable = 1'b0;
    ticks(1);
    check("down_no_jump", 32'(dut.r_g), 100);
    prev_g = 100; bad_mono = 0;
    for (int t = 0; t < 199; t++) begin
      ticks(1);
      if (int'(dut.r_g) > prev_g || prev_g - int'(dut.r_g) > 1) bad_mono++;
      prev_g = int'(dut.r_g);
    end
    check("down_monotonic", 32'(bad_mono), 0);
    check("down_g1", 32'(dut.r_g), 1);
    check("down_not_muted", 32'(muted), 0);
    ticks(1);
    check("down_g0", 32'(dut.r_g), 0);
    check("down_muted", 32'(muted), 1);
    check("down_int1", 32'(dut.r_int1), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_dac.md
SIGMA_DELTA_DAC -- requirements
Module: sigma_delta_dac

Interface
REQ-001 SHALL have parameter MOD_DIV, default 4, meaning clk cycles per modulator tick (range 1..255).
REQ-002 SHALL have parameter RAMP_STEP, default 64, meaning modulator ticks per gain step during soft mute/unmute (range 1..65535).
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port sample_in, input, 16, signed held PCM sample from the upsampler; may change on any cycle.
REQ-006 SHALL have port enable, input, 1: high requests unmute, low requests mute.
REQ-007 SHALL have port pdm_out, output, 1, registered 1-bit modulator output to the DAC pin.
REQ-008 SHALL have port muted, output, 1: high only in state MUTED.
REQ-009 SHALL have port overload, output, 1: one-cycle pulse when an integrator clamps.

Function
REQ-010 SHALL generate a tick strobe from a divider counter that counts 0..MOD_DIV-1 and pulses tick when the count equals MOD_DIV-1; all modulator state updates occur only on tick cycles.
REQ-011 SHALL capture sample_in into an input register on each tick; that captured value is used on the next tick.
REQ-012 SHALL scale the captured sample by gain g (9-bit unsigned, 0..256): x = (sample * g) >>> 8, 16-bit signed result.
REQ-013 SHALL use feedback fb = +32767 when pdm_out is 1 and -32768 when pdm_out is 0.
REQ-014 SHALL implement a second-order loop per tick: int1 <= int1 + x - fb (20-bit signed); int2 <= int2 + int1_new - fb (24-bit signed); pdm_out <= (int2_new >= 0).
REQ-015 SHALL clamp int1 to +/-2^18 and int2 to +/-2^22, asserting overload for exactly one clk cycle on any tick where a clamp occurs.
REQ-016 SHALL implement FSM states MUTED, RAMP_UP, RUN, RAMP_DOWN.
REQ-017 MUTED: g=0, int1=int2=0, pdm_out toggles every tick (zero-mean idle pattern); enable high -> RAMP_UP on the next tick.
REQ-018 RAMP_UP: g increments by 1 every RAMP_STEP ticks; g reaching 256 -> RUN; enable low -> RAMP_DOWN from the current g without a jump.
REQ-019 RUN: g=256 (unity); enable low -> RAMP_DOWN.
REQ-020 RAMP_DOWN: g decrements by 1 every RAMP_STEP ticks; g reaching 0 -> MUTED; enable high -> RAMP_UP from the current g.
REQ-021 SHALL evaluate enable only on tick cycles; enable toggling between ticks has no effect.
REQ-022 SHALL restart the RAMP_STEP counter at 0 on every state transition.
REQ-023 SHALL use a total latency of 2 ticks from a sample_in change to the first pdm_out bit that reflects it.

Reset
REQ-024 SHALL, while rst=0, set state=MUTED, g=0, int1=int2=0, divider=0, RAMP_STEP counter=0, input register=0, pdm_out=0, muted=1, overload=0.
REQ-025 SHALL, on reset asserted mid-ramp or in RUN, discard all state in the same cycle with no output ramp.
REQ-026 SHALL produce the first tick MOD_DIV cycles after rst deasserts.

Configuration
REQ-027 SHALL compile in, when macro SIGMA_DELTA_DITHER_EN is defined, a 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advanced each tick, whose low 2 bits are sign-extended and added to x before int1.
REQ-028 SHALL, without SIGMA_DELTA_DITHER_EN, contain no LFSR, and x enters int1 unmodified.
REQ-029 SHALL, with SIGMA_DELTA_DITHER_EN defined, hold the LFSR at its seed in MUTED.

Verification
REQ-030 SHALL cover: reset, enable=0, MOD_DIV=4 -> muted=1, pdm_out toggles every 4 clks, integrators 0.
REQ-031 SHALL cover: enable=1, sample_in=0, RAMP_STEP=2 -> RUN reached after 512 ticks; muted falls one tick after enable is seen; pdm_out density 50% +/-1% over 4096 ticks.
REQ-032 SHALL cover: RUN, sample_in=16'h4000 -> pdm_out ones density 75% +/-0.5% over 8192 ticks; overload never pulses.
REQ-033 SHALL cover: RUN, sample_in=16'h7FFF held -> no overflow wrap, ones density >= 99%, any clamp yields 1-cycle overload pulses only.
REQ-034 SHALL cover: enable dropped at g=100 during RAMP_UP -> RAMP_DOWN, g decreases monotonically 100->0, then MUTED with muted=1.
REQ-035 SHALL cover: rst asserted in RUN with sample_in=16'h4000 -> next cycle all outputs at reset values; after release the block restarts in MUTED.
